sync_fifo_prog: RTL and testbench

//   Single-clock parametrised FIFO for same-domain buffering between pipeline stages.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_mem_sdp.sv | 49 ++++
 rtl/sync_fifo_prog.sv | 123 ++++++++++++
 tb/tb_sync_fifo_prog.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable single-clock FIFO: error codes and
// the width helper used to size the level/pointer/threshold buses.
package fifo_pkg;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_OVERFLOW  = 2'b01,
    ERR_UNDERFLOW = 2'b10
  } fifo_err_e;

  // Level needs one bit more than the address so that DEPTH itself is representable.
  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port storage: one write port, one read port that is either
// combinational (fall-through) or registered with a hold-on-idle output.
module fifo_mem_sdp #(
  parameter int DWIDTH  = 8,
  parameter int DEPTH   = 16,
  parameter bit SYNC_RD = 1'b0,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  generate
    if (SYNC_RD) begin : g_sync_rd
      logic [DWIDTH-1:0] rdata_q;

      // Output only moves on an accepted read, otherwise it holds the last word.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= '0;
        end else if (re) begin
          rdata_q <= mem_q[raddr];
        end
      end

      assign rdata = rdata_q;
    end else begin : g_async_rd
      logic unused_sync_ctrl;

      assign unused_sync_ctrl = &{1'b0, rst, re};
      assign rdata            = mem_q[raddr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, exact level,
// FWFT or registered read, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  parameter bit FWFT   = 1'b1,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              w_en,
  input  logic [DWIDTH-1:0] wdata,
  output logic              wfull,
  input  logic              r_en,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid,
  output logic              rempty,
  input  logic [AWIDTH:0]   af_thresh,
  input  logic [AWIDTH:0]   ae_thresh,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AWIDTH:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int LW = lvl_width(DEPTH);
  localparam logic [LW-1:0] PTR_ONE  = LW'(1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [LW-1:0]     wptr_q, wptr_d;
  logic [LW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              wfull_q, rempty_q, af_q, ae_q, rvalid_q;
  logic [1:0]        err_q, err_d, err_set;
  logic              rd_ok, wr_ok, wr_commit, rd_commit;
  logic [DWIDTH-1:0] mem_rdata;

  // A write into a full FIFO is legal only when a read frees the slot this same cycle.
  assign rd_ok = r_en & ~rempty_q;
  assign wr_ok = w_en & (~wfull_q | rd_ok);

  assign wr_commit = wr_ok & ~flush & ~rst;
  assign rd_commit = rd_ok & ~flush & ~rst;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + PTR_ONE;
      if (rd_ok) rptr_d = rptr_q + PTR_ONE;
    end
    level_d = wptr_d - rptr_d;
  end

  always_comb begin
    err_set = ERR_NONE;
    if (!flush) begin
      if (w_en && !wr_ok)    err_set = err_set | ERR_OVERFLOW;
      if (r_en && rempty_q)  err_set = err_set | ERR_UNDERFLOW;
    end
    // A new error in the same cycle as err_clr wins.
    err_d = err_set | (err_q & ~{2{err_clr}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      af_q     <= (af_thresh == '0);
      ae_q     <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      wfull_q  <= (level_d == FULL_LVL);
      rempty_q <= (level_d == '0);
      af_q     <= (level_d >= af_thresh);
      ae_q     <= (level_d <= ae_thresh);
      rvalid_q <= rd_commit;
      err_q    <= err_d;
    end
  end

  fifo_mem_sdp #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .SYNC_RD(!FWFT)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_commit),
    .waddr(wptr_q[AWIDTH-1:0]),
    .wdata(wdata),
    .re   (rd_commit),
    .raddr(rptr_q[AWIDTH-1:0]),
    .rdata(mem_rdata)
  );

  // In fall-through mode the head slot is stale while empty, so present zero instead.
  assign rdata        = FWFT ? (rempty_q ? '0 : mem_rdata) : mem_rdata;
  assign rvalid       = FWFT ? ~rempty_q : rvalid_q;
  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign level        = level_q;
  assign overflow     = |(err_q & ERR_OVERFLOW);
  assign underflow    = |(err_q & ERR_UNDERFLOW);

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench: FWFT and registered-read instances driven in lockstep,
// expected read data kept in a queue filled on accepted writes.
module tb_sync_fifo_prog;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = $clog2(DP);

  logic          clk = 1'b0;
  logic          rst, flush, w_en, r_en, err_clr;
  logic [DW-1:0] wdata;
  logic [AW:0]   af_thresh, ae_thresh;

  logic          wfull, rvalid, rempty, almost_full, almost_empty, overflow, underflow;
  logic [DW-1:0] rdata;
  logic [AW:0]   level;

  logic          wfull0, rvalid0, rempty0, af0, ae0, ovf0, udf0;
  logic [DW-1:0] rdata0;
  logic [AW:0]   level0;

  int vectors     = 0;
  int miscompares = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] exp_d;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DWIDTH(DW), .DEPTH(DP), .FWFT(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .wdata(wdata), .wfull(wfull),
    .r_en(r_en), .rdata(rdata), .rvalid(rvalid), .rempty(rempty),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .almost_full(almost_full),
    .almost_empty(almost_empty), .level(level), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  sync_fifo_prog #(.DWIDTH(DW), .DEPTH(DP), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .wdata(wdata), .wfull(wfull0),
    .r_en(r_en), .rdata(rdata0), .rvalid(rvalid0), .rempty(rempty0),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .almost_full(af0),
    .almost_empty(ae0), .level(level0), .overflow(ovf0),
    .underflow(udf0), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    w_en  = 1'b1;
    wdata = d;
    sb_q.push_back(d);
    tick();
    w_en  = 1'b0;
  endtask

  // Check the FWFT head against the scoreboard, then pop it.
  task automatic rd(input string tag);
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      exp_d = sb_q.pop_front();
      chk(tag, 32'(rdata), 32'(exp_d));
    end
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
    wdata = '0; af_thresh = 5'd12; ae_thresh = 5'd4;
    tick();
    tick();
    chk("rst_level",  32'(level), 32'd0);
    chk("rst_rempty", 32'(rempty), 32'd1);
    chk("rst_wfull",  32'(wfull), 32'd0);
    chk("rst_ae",     32'(almost_empty), 32'd1);
    chk("rst_af",     32'(almost_full), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_errs",   32'({overflow, underflow}), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    rst = 1'b0;

    // Fill to full, then one write too many.
    for (int i = 0; i < DP; i++) wr(DW'(i));
    chk("fill_wfull", 32'(wfull), 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_af",    32'(almost_full), 32'd1);
    w_en = 1'b1; wdata = 8'h99;
    tick();
    w_en = 1'b0;
    chk("ovf_set",   32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    af_thresh = 5'd17;
    tick();
    chk("af_above_depth", 32'(almost_full), 32'd0);
    af_thresh = 5'd12;
    tick();
    chk("af_restored", 32'(almost_full), 32'd1);

    // Drain in order, then read from empty.
    for (int i = 0; i < DP; i++) rd($sformatf("drain_%0d", i));
    chk("drain_rempty", 32'(rempty), 32'd1);
    chk("drain_rvalid", 32'(rvalid), 32'd0);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("udf_set",   32'(underflow), 32'd1);
    chk("udf_level", 32'(level), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 32'({overflow, underflow}), 32'd0);

    // Full with simultaneous write and read; pointers wrap through 31->0.
    for (int i = 0; i < DP; i++) wr(DW'(8'h20 + i));
    chk("sim_head", 32'(rdata), 32'h20);
    void'(sb_q.pop_front());
    sb_q.push_back(8'hAA);
    w_en = 1'b1; r_en = 1'b1; wdata = 8'hAA;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    chk("sim_level", 32'(level), 32'd16);
    chk("sim_wfull", 32'(wfull), 32'd1);
    chk("sim_no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DP; i++) rd($sformatf("wrap_%0d", i));
    chk("wrap_empty", 32'(rempty), 32'd1);

    // Threshold crossings at af=10, ae=4.
    af_thresh = 5'd10; ae_thresh = 5'd4;
    for (int i = 0; i < 9; i++) wr(DW'(8'h40 + i));
    chk("lvl9_af", 32'(almost_full), 32'd0);
    wr(8'h49);
    chk("lvl10_af", 32'(almost_full), 32'd1);
    for (int i = 0; i < 5; i++) rd($sformatf("thr_%0d", i));
    chk("lvl5_ae", 32'(almost_empty), 32'd0);
    rd("thr_5");
    chk("lvl4_ae", 32'(almost_empty), 32'd1);
    chk("lvl4_level", 32'(level), 32'd4);
    for (int i = 6; i < 10; i++) rd($sformatf("thr_%0d", i));
    r_en = 1'b1; err_clr = 1'b1;
    tick();
    r_en = 1'b0;
    chk("set_beats_clr", 32'(underflow), 32'd1);
    tick();
    err_clr = 1'b0;
    chk("clr_udf", 32'(underflow), 32'd0);

    // Flush at level 7 with a concurrent write.
    for (int i = 0; i < 7; i++) wr(DW'(8'h60 + i));
    chk("pre_flush_level", 32'(level), 32'd7);
    flush = 1'b1; w_en = 1'b1; wdata = 8'h77;
    tick();
    flush = 1'b0; w_en = 1'b0;
    sb_q.delete();
    chk("flush_level",  32'(level), 32'd0);
    chk("flush_rempty", 32'(rempty), 32'd1);
    chk("flush_ae",     32'(almost_empty), 32'd1);
    wr(8'h33);
    rd("post_flush");
    chk("post_flush_empty", 32'(rempty), 32'd1);

    // Reset mid-burst with a write pending.
    wr(8'h34);
    wr(8'h35);
    rst = 1'b1; w_en = 1'b1; wdata = 8'h36;
    tick();
    rst = 1'b0; w_en = 1'b0;
    sb_q.delete();
    chk("mrst_level",  32'(level), 32'd0);
    chk("mrst_rempty", 32'(rempty), 32'd1);
    chk("mrst_wfull",  32'(wfull), 32'd0);
    chk("mrst_rvalid", 32'(rvalid), 32'd0);
    chk("mrst_rdata",  32'(rdata), 32'd0);
    chk("mrst_rdata0", 32'(rdata0), 32'd0);

    // Registered-read instance: one-cycle rvalid pulse, data held afterwards.
    wr(8'h55);
    chk("fwft_vis",  32'(rdata), 32'h55);
    chk("reg_idle_rvalid", 32'(rvalid0), 32'd0);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("reg_rvalid", 32'(rvalid0), 32'd1);
    chk("reg_rdata",  32'(rdata0), 32'h55);
    tick();
    chk("reg_rvalid_low", 32'(rvalid0), 32'd0);
    chk("reg_rdata_hold", 32'(rdata0), 32'h55);
    chk("reg_empty", 32'(rempty0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
